// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: load handshake and display bus between the SAP-1 output register and the scan controller
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                en;
  logic [4*DIGITS-1:0] value;
  logic                load_valid;
  logic                load_ready;
  logic [3:0]          bcd;
  logic [DIGITS-1:0]   digit_an;
  logic                frame_done;
  modport master (
    output en, value, load_valid,
    input  load_ready, bcd, digit_an, frame_done
  );
  modport slave (
    input  en, value, load_valid,
    output load_ready, bcd, digit_an, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed seven-segment scan controller; define SEG_LZ_BLANK_EN for leading-zero blanking
module seg_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input logic            clk,
  input logic            rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int VW = 4 * DIGITS;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_n;
  logic [VW-1:0] active, active_n, pending, pending_n;
  logic pend_full, pend_full_n, have_val, have_val_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [3:0] bcd, bcd_n;
  logic [DIGITS-1:0] an, an_n, lit;
  logic fd, fd_n, accept, tick, fend;
  assign bus.load_ready = !pend_full;
  assign bus.bcd        = bcd;
  assign bus.digit_an   = an;
  assign bus.frame_done = fd;
  // Next state: load routing, slot/frame counting, frame-boundary value swap and registered display outputs
  always_comb begin
    accept      = bus.load_valid && !pend_full;
    tick        = state == SCAN && pcnt == PMAX;
    fend        = tick && idx == IMAX;
    state_n     = state;
    active_n    = active;
    pending_n   = pending;
    pend_full_n = pend_full;
    have_val_n  = have_val;
    pcnt_n      = '0;
    idx_n       = '0;
    fd_n        = fend;
    if (state == IDLE) begin
      if (accept) begin
        active_n   = bus.value;
        have_val_n = 1'b1;
      end
      if (bus.en && have_val_n) state_n = SCAN;
    end else begin
      if (fend && pend_full) begin
        active_n    = pending;
        pend_full_n = 1'b0;
      end else if (accept) begin
        pending_n   = bus.value;
        pend_full_n = 1'b1;
      end
      if (bus.en) begin
        pcnt_n = tick ? '0 : pcnt + 1'b1;
        idx_n  = tick ? (idx == IMAX ? '0 : idx + 1'b1) : idx;
      end else state_n = IDLE;
    end
`ifdef SEG_LZ_BLANK_EN
    begin
      logic acc;
      acc = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        acc    = acc | (|active_n[4*i +: 4]);
        lit[i] = acc || (i == 0);
      end
    end
`else
    lit = '1;
`endif
    bcd_n = state_n == SCAN ? active_n[4*idx_n +: 4] : 4'd0;
    an_n  = (state_n == SCAN && lit[idx_n]) ? DIGITS'(1) << idx_n : '0;
  end
  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      active    <= '0;
      pending   <= '0;
      pend_full <= 1'b0;
      have_val  <= 1'b0;
      pcnt      <= '0;
      idx       <= '0;
      bcd       <= '0;
      an        <= '0;
      fd        <= 1'b0;
    end else begin
      state     <= state_n;
      active    <= active_n;
      pending   <= pending_n;
      pend_full <= pend_full_n;
      have_val  <= have_val_n;
      pcnt      <= pcnt_n;
      idx       <= idx_n;
      bcd       <= bcd_n;
      an        <= an_n;
      fd        <= fd_n;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed and random stimulus against a time-based reference model of the scan controller
module tb_seg_scan_ctrl;
  localparam int D = 4;
  localparam int RD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seg_scan_ctrl_if #(.DIGITS(D)) bus ();
  seg_scan_ctrl #(.DIGITS(D), .REFRESH_DIV(RD)) dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  logic scanning, have, qfull, fd;
  int t;
  logic [4*D-1:0] shown, queued;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic mreset;
    scanning = 0; have = 0; qfull = 0; fd = 0; t = 0; shown = '0; queued = '0;
  endtask
  task automatic mstep;
    logic acc, fend;
    acc  = bus.load_valid && !qfull;
    fend = scanning && (t % (D*RD) == D*RD - 1);
    fd   = fend;
    if (!scanning) begin
      if (acc) begin shown = bus.value; have = 1; end
      if (bus.en && have) begin scanning = 1; t = 0; end
    end else begin
      if (fend && qfull) begin shown = queued; qfull = 0; end
      else if (acc) begin queued = bus.value; qfull = 1; end
      if (bus.en) t++;
      else scanning = 0;
    end
  endtask
  task automatic check_outs;
    int d;
    logic [3:0] eb;
    logic [D-1:0] ea;
    eb = '0;
    ea = '0;
    if (scanning) begin
      d  = (t / RD) % D;
      eb = shown[4*d +: 4];
      ea = D'(1) << d;
`ifdef SEG_LZ_BLANK_EN
      if (d > 0 && (shown >> (4*d)) == 0) ea = '0;
`endif
    end
    chk("bcd", 32'(bus.bcd), 32'(eb));
    chk("digit_an", 32'(bus.digit_an), 32'(ea));
    chk("load_ready", 32'(bus.load_ready), 32'(!qfull));
    chk("frame_done", 32'(bus.frame_done), 32'(fd));
  endtask
  task automatic cyc(input logic e, input logic lv, input logic [4*D-1:0] v);
    bus.en = e;
    bus.load_valid = lv;
    bus.value = v;
    @(posedge clk);
    if (rst) mreset();
    else mstep();
    #1;
    check_outs();
  endtask
  initial begin
    logic [4*D-1:0] rv;
    bus.en = 0;
    bus.load_valid = 0;
    bus.value = '0;
    mreset();
    #1;
    check_outs();
    #11 rst = 0;
    repeat (20) cyc(1, 0, '0);
    cyc(1, 1, 16'h1234);
    repeat (20) cyc(1, 0, '0);
    cyc(1, 1, 16'hABCD);
    chk("ready_after_accept", 32'(bus.load_ready), 32'd0);
    repeat (40) cyc(1, 0, '0);
    for (int i = 0; i < 16 && !(scanning && (t / RD) % D == 2); i++) cyc(1, 0, '0);
    cyc(0, 0, '0);
    chk("en_drop_dark", 32'(bus.digit_an), 32'd0);
    repeat (3) cyc(0, 0, '0);
    repeat (20) cyc(1, 0, '0);
    cyc(1, 1, 16'h5555);
    repeat (2) cyc(1, 0, '0);
    #2 rst = 1;
    #1;
    chk("rst_async_bcd", 32'(bus.bcd), 32'd0);
    chk("rst_async_an", 32'(bus.digit_an), 32'd0);
    chk("rst_async_ready", 32'(bus.load_ready), 32'd1);
    mreset();
    #3 rst = 0;
    repeat (10) cyc(1, 0, '0);
    cyc(1, 1, 16'h0070);
    repeat (20) cyc(1, 0, '0);
    repeat (3000) begin
      rv = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rv = rv & (16'hFFFF >> (4 * $urandom_range(1, 3)));
      cyc($urandom_range(0, 19) != 0, $urandom_range(0, 5) == 0, rv);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
